i2s_frame_sequencer: RTL and testbench
======================================

# i2s_frame_sequencer

Controller that sequences the I2S output serializer of the microphone-summing path. It generates the bit clock (sck) and word select (ws) from the system clock. It arbitrates the single serial output between a left-channel and a right-channel sample source, using per-channel valid/ready holding registers. It also emits the load strobe and shift timing that feed the downstream output-mux/shift stage.

## Interface
- WIDTH, 16, bits per channel sample (>= 2)
- DIV, 2, clk cycles per sck half-period (>= 2)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  start/continue streaming; deassert = stop after current frame
- l_data  in  WIDTH  left sample, two's complement, MSB first on the wire
- l_valid  in  1  left sample offered
- l_ready  out  1  left holding register empty
- r_data  in  WIDTH  right sample
- r_valid  in  1  right sample offered
- r_ready  out  1  right holding register empty
- sck  out  1  I2S bit clock, registered
- ws  out  1  word select (lr_clk): 0 = left, 1 = right, registered
- sd  out  1  serial data, registered
- load_strobe  out  1  one-clk pulse when a channel's shift register is loaded (MSB driven)
- underflow  out  1  one-clk pulse when a load finds its holding register empty
- busy  out  1  1 while in RUN or DRAIN

## Operation
- States:
  - IDLE: sck=0, ws=0, sd=0, divider=0, bit_idx=0, channel=left.
  - RUN: streaming frames.
  - DRAIN: finishing the current frame after enable drops.
- IDLE -> RUN when enable=1. RUN -> DRAIN when enable=0, sampled at any clk. DRAIN -> IDLE at the falling event that would drive the next left MSB; that event drives sd=0, ws=0, and no load occurs. DRAIN -> RUN if enable re-asserts before that event; frame timing is unaffected.
- Divider: counts 0..DIV-1 in RUN/DRAIN. At DIV-1 it wraps and sck toggles. A "falling event" is the clk edge where sck goes 1->0.
- All sd/ws/shift updates happen only on falling events.
- At each falling event, sd takes the next bit. bit_idx advances 0..WIDTH-1 per channel and wraps, and channel flips on wrap.
- Load: at the falling event with bit_idx=0, the shift register loads from the current channel's holding register, sd = MSB, and load_strobe pulses.
  - If the holding register is empty, the shift register loads all zeros and underflow pulses (together with load_strobe).
- ws (I2S one-bit delay): ws goes to 1 at the falling event driving the left LSB, and returns to 0 at the falling event driving the right LSB. The MSB of each channel is driven one sck period after ws changes.
- Handshake: x_ready = holding register empty. A sample is accepted on the clk edge where x_valid & x_ready. Acceptance is independent of state, including IDLE.
- Simultaneous accept and load on one edge: the load sees the pre-edge state. If empty, the load underflows and the accepted word is stored for the next frame of that channel.
- Holding registers are freed on load, so x_ready=1 on the next clk.

## Timing
- Reset values: sck=0, ws=0, sd=0, load_strobe=0, underflow=0, busy=0, l_ready=1, r_ready=1, holding registers empty, state IDLE.
- Reset asserted mid-frame forces all of the above on the same clk edge; any partial sample is discarded.
- First sck rise occurs DIV clks after entering RUN. The first falling event (left MSB, first load_strobe) occurs 2*DIV clks after entering RUN.
- One sck period = 2*DIV clk. One frame = 2*WIDTH sck periods = 4*WIDTH*DIV clk.
- Latency from accept to that word's MSB on sd is at most one frame plus 2*DIV clk.
- sd, ws and sck change on the same clk edge. Downstream logic samples sd on sck rising.

## Test plan
- Reset, then enable with WIDTH=16, DIV=2, l=0xA5A5 and r=0x3C3C preloaded:
  - first load_strobe at clk 4;
  - sd on sck rises reads A5A5 then 3C3C MSB-first;
  - ws rises at the left-LSB falling event;
  - frame period 128 clk.
- Enable with r holding empty, l=0x8001 loaded: right slot reads 0x0000, underflow pulses exactly once, left is unaffected.
- Offer r_valid on the exact clk of the right load while r is empty: underflow pulses; the next frame's right slot carries the offered word.
- Drop enable mid-right-channel:
  - frame completes, then IDLE; sck/ws/sd return to 0 and busy=0;
  - no load_strobe for the next left.
- Assert rst at bit 7 of left: all outputs take reset values on that edge, ready=1; re-enable restarts with a clean first frame.
- Continuous random valid stalls over 50 frames: received stream equals accepted stream in order, and the underflow count equals the number of zero-filled slots.

Source files
------------

// File: rtl/i2s_frame_sequencer.sv
// I2S frame sequencer: derives sck/ws from clk, arbitrates left/right holding
// registers into one shift register, and emits load/underflow strobes.
module i2s_frame_sequencer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIV   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] l_data,
   input  logic             l_valid,
   output logic             l_ready,
   input  logic [WIDTH-1:0] r_data,
   input  logic             r_valid,
   output logic             r_ready,
   output logic             sck,
   output logic             ws,
   output logic             sd,
   output logic             load_strobe,
   output logic             underflow,
   output logic             busy
);

   localparam int unsigned DW = $clog2(DIV);
   localparam int unsigned BW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   state_e           state_q;
   logic [DW-1:0]    div_q;
   logic [BW-1:0]    bit_q;
   logic             chan_q;
   logic             sck_q;
   logic             ws_q;
   logic             sd_q;
   logic             ls_q;
   logic             uf_q;
   logic             busy_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] l_hold_q;
   logic             l_full_q;
   logic [WIDTH-1:0] r_hold_q;
   logic             r_full_q;

   logic             div_wrap;
   logic             fall_evt;
   logic             slot_start;
   logic             slot_last;
   logic             stop_evt;
   logic             load_evt;
   logic             load_full;
   logic [WIDTH-1:0] load_word_d;
   logic             l_acc;
   logic             r_acc;

   always_comb begin
      div_wrap    = (div_q == DW'(DIV - 1));
      fall_evt    = (state_q != IDLE) && div_wrap && sck_q;
      slot_start  = (bit_q == '0);
      slot_last   = (bit_q == BW'(WIDTH - 1));
      // Draining ends exactly where the next left MSB would be driven.
      stop_evt    = fall_evt && (state_q == DRAIN) && slot_start && !chan_q;
      load_evt    = fall_evt && slot_start && !stop_evt;
      load_full   = chan_q ? r_full_q : l_full_q;
      load_word_d = '0;
      if (load_full) begin
         load_word_d = chan_q ? r_hold_q : l_hold_q;
      end
      l_acc = l_valid && !l_full_q;
      r_acc = r_valid && !r_full_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         chan_q   <= 1'b0;
         sck_q    <= 1'b0;
         ws_q     <= 1'b0;
         sd_q     <= 1'b0;
         ls_q     <= 1'b0;
         uf_q     <= 1'b0;
         busy_q   <= 1'b0;
         shift_q  <= '0;
         l_hold_q <= '0;
         l_full_q <= 1'b0;
         r_hold_q <= '0;
         r_full_q <= 1'b0;
      end else begin
         ls_q <= 1'b0;
         uf_q <= 1'b0;

         // An accept on a loading edge wins: the load already saw "empty".
         if (l_acc) begin
            l_hold_q <= l_data;
            l_full_q <= 1'b1;
         end else if (load_evt && !chan_q) begin
            l_full_q <= 1'b0;
         end
         if (r_acc) begin
            r_hold_q <= r_data;
            r_full_q <= 1'b1;
         end else if (load_evt && chan_q) begin
            r_full_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               if (stop_evt) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  div_q   <= '0;
                  bit_q   <= '0;
                  chan_q  <= 1'b0;
                  sck_q   <= 1'b0;
                  ws_q    <= 1'b0;
                  sd_q    <= 1'b0;
               end else begin
                  state_q <= enable ? RUN : DRAIN;
                  div_q   <= div_wrap ? '0 : div_q + 1'b1;
                  if (div_wrap) begin
                     sck_q <= ~sck_q;
                  end
                  if (fall_evt) begin
                     if (slot_start) begin
                        sd_q    <= load_word_d[WIDTH-1];
                        shift_q <= {load_word_d[WIDTH-2:0], 1'b0};
                        ls_q    <= 1'b1;
                        uf_q    <= !load_full;
                     end else begin
                        sd_q    <= shift_q[WIDTH-1];
                        shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                     end
                     // ws leads the channel by one bit: flips while driving the LSB.
                     if (slot_last) begin
                        ws_q   <= ~chan_q;
                        bit_q  <= '0;
                        chan_q <= ~chan_q;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign l_ready     = ~l_full_q;
   assign r_ready     = ~r_full_q;
   assign sck         = sck_q;
   assign ws          = ws_q;
   assign sd          = sd_q;
   assign load_strobe = ls_q;
   assign underflow   = uf_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: directed scenarios plus random stalls,
// checked every clk against a timing/slot model computed from clk counts.
module tb_i2s_frame_sequencer;

   localparam int unsigned W     = 16;
   localparam int unsigned D     = 2;
   localparam int unsigned PER   = 2 * D;
   localparam int unsigned FRAME = 4 * W * D;

   logic         clk;
   logic         rst;
   logic         enable;
   logic [W-1:0] l_data;
   logic         l_valid;
   logic         l_ready;
   logic [W-1:0] r_data;
   logic         r_valid;
   logic         r_ready;
   logic         sck;
   logic         ws;
   logic         sd;
   logic         load_strobe;
   logic         underflow;
   logic         busy;

   i2s_frame_sequencer #(.WIDTH(W), .DIV(D)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .l_data(l_data), .l_valid(l_valid), .l_ready(l_ready),
      .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
      .sck(sck), .ws(ws), .sd(sd),
      .load_strobe(load_strobe), .underflow(underflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // reference model: session time counter and per-slot arithmetic
   bit           m_act = 0;
   bit           m_en_prev = 0;
   int unsigned  m_t = 0;
   logic         m_lfull = 0, m_rfull = 0;
   logic [W-1:0] m_lhold = '0, m_rhold = '0, m_word = '0;
   logic         m_sck = 0, m_ws = 0, m_sd = 0, m_ls = 0, m_uf = 0;
   int unsigned  m_uf_cnt = 0;
   logic [W-1:0] exp_q[$];

   // observation side
   int unsigned  cyc = 0;
   int unsigned  obs_uf_cnt = 0;
   int unsigned  ls_cyc[$];
   int unsigned  ws_rise_cyc = 0;
   logic         sck_prev = 0, ws_prev = 0;
   logic [W-1:0] rx_sh = '0;
   int unsigned  rx_n = 0;
   bit           rx_on = 0;
   logic [W-1:0] rx_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic model_edge();
      bit           la, ra, full;
      logic [W-1:0] ld, rd;
      int unsigned  s, b, ch;
      if (rst) begin
         m_act = 0; m_en_prev = 0; m_t = 0;
         m_lfull = 0; m_rfull = 0;
         m_sck = 0; m_ws = 0; m_sd = 0; m_ls = 0; m_uf = 0;
         exp_q.delete();
         return;
      end
      la = l_valid && !m_lfull; ld = l_data;
      ra = r_valid && !m_rfull; rd = r_data;
      m_ls = 0; m_uf = 0;
      if (!m_act) begin
         if (enable) begin
            m_act = 1;
            m_t = 0;
         end
      end else begin
         m_t++;
         m_sck = ((m_t / D) % 2) == 1;
         if (m_t % PER == 0) begin
            s  = m_t / PER - 1;
            b  = s % W;
            ch = (s / W) % 2;
            if (b == 0 && ch == 0 && !m_en_prev) begin
               m_act = 0; m_sck = 0; m_ws = 0; m_sd = 0;
            end else begin
               if (b == 0) begin
                  full   = (ch == 1) ? m_rfull : m_lfull;
                  m_word = full ? ((ch == 1) ? m_rhold : m_lhold) : '0;
                  m_ls   = 1;
                  m_uf   = !full;
                  if (!full) m_uf_cnt++;
                  exp_q.push_back(m_word);
                  if (ch == 1) m_rfull = 0; else m_lfull = 0;
               end
               m_sd = m_word[W-1-b];
               if (b == W - 1) m_ws = (ch == 0);
            end
         end
      end
      if (la) begin m_lfull = 1; m_lhold = ld; end
      if (ra) begin m_rfull = 1; m_rhold = rd; end
      m_en_prev = enable;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("sck", sck, m_sck);
      chk("ws", ws, m_ws);
      chk("sd", sd, m_sd);
      chk("load_strobe", load_strobe, m_ls);
      chk("underflow", underflow, m_uf);
      chk("busy", busy, m_act);
      chk("l_ready", l_ready, !m_lfull);
      chk("r_ready", r_ready, !m_rfull);
      if (rst) begin
         rx_q.delete(); rx_on = 0; rx_n = 0;
      end else begin
         if (load_strobe) begin
            ls_cyc.push_back(cyc);
            rx_on = 1; rx_n = 0;
         end else if (rx_on && sck && !sck_prev) begin
            rx_sh = {rx_sh[W-2:0], sd};
            rx_n++;
            if (rx_n == W) begin
               rx_q.push_back(rx_sh);
               rx_on = 0;
            end
         end
         if (underflow) obs_uf_cnt++;
         if (ws && !ws_prev && ws_rise_cyc == 0) ws_rise_cyc = cyc;
      end
      sck_prev = sck;
      ws_prev  = ws;
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   task automatic run_until_idle(input int unsigned maxc);
      int unsigned k = 0;
      while (busy === 1'b1 && k < maxc) begin
         step();
         k++;
      end
      chk("drain_to_idle", busy, 1'b0);
   endtask

   task automatic cmp_streams(input string tag);
      int unsigned n;
      chk({tag, "_len"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int unsigned i = 0; i < n; i++) chk({tag, "_word"}, rx_q[i], exp_q[i]);
   endtask

   task automatic clear_obs();
      rx_q.delete(); exp_q.delete(); ls_cyc.delete();
   endtask

   task automatic offer(input logic [W-1:0] ld, input bit lv, input logic [W-1:0] rd, input bit rv);
      l_data = ld; l_valid = lv; r_data = rd; r_valid = rv;
      step();
      l_valid = 0; r_valid = 0;
   endtask

   int unsigned start, n_ls, uf_snap, muf_snap, k, zeros;

   initial begin
      rst = 1; enable = 0; l_valid = 0; r_valid = 0; l_data = '0; r_data = '0;
      run(2);
      rst = 0;
      run(2);

      // preloaded words, first frame timing and frame period
      offer(16'hA5A5, 1, 16'h3C3C, 1);
      step();
      clear_obs();
      ws_rise_cyc = 0;
      enable = 1;
      step();
      start = cyc;
      run(2 * FRAME + 8);
      if (ls_cyc.size() >= 3) begin
         chk("first_load_clk", ls_cyc[0] - start, PER);
         chk("frame_period", ls_cyc[2] - ls_cyc[0], FRAME);
      end else begin
         chk("load_count", ls_cyc.size(), 3);
      end
      chk("ws_rise_left_lsb", ws_rise_cyc - start, W * PER);
      chk("rx_left", rx_q[0], 16'hA5A5);
      chk("rx_right", rx_q[1], 16'h3C3C);

      // drop enable mid-right: finish frame, no next-left load
      run(FRAME / 2);
      enable = 0;
      n_ls = ls_cyc.size();
      run_until_idle(FRAME + 16);
      chk("no_left_load_after_drain", ls_cyc.size(), n_ls);
      chk("idle_sck", sck, 1'b0);
      chk("idle_ws", ws, 1'b0);
      cmp_streams("drain_stream");
      run(4);

      // right holding empty: one underflow, zero slot
      offer(16'h8001, 1, 16'h0000, 0);
      clear_obs();
      uf_snap = obs_uf_cnt;
      enable = 1;
      run(FRAME / 2 + 3 * PER);
      enable = 0;
      run_until_idle(FRAME + 16);
      chk("uf_once", obs_uf_cnt - uf_snap, 1);
      chk("uf_left_word", rx_q[0], 16'h8001);
      chk("uf_right_zero", rx_q[1], 16'h0000);
      run(4);

      // offer right word on the exact right-load edge
      clear_obs();
      enable = 1;
      k = 0;
      while (!(m_act && ((m_t + 1) % PER == 0) && (((m_t + 1) / PER - 1) % (2 * W) == W)) && k < 4 * FRAME) begin
         step();
         k++;
      end
      chk("reach_right_load", k < 4 * FRAME, 1'b1);
      offer(16'h0000, 0, 16'h1234, 1);
      chk("uf_at_right_load", underflow, 1'b1);
      chk("held_after_race", r_ready, 1'b0);
      run(FRAME);
      enable = 0;
      run_until_idle(FRAME + 16);
      chk("race_slot_zero", rx_q[1], 16'h0000);
      chk("race_next_frame", rx_q[3], 16'h1234);
      cmp_streams("race_stream");
      run(4);

      // reset at left bit 7, then clean restart
      offer(16'h1111, 1, 16'h2222, 1);
      clear_obs();
      enable = 1;
      run(1 + 8 * PER);
      rst = 1;
      enable = 0;
      step();
      chk("rst_l_ready", l_ready, 1'b1);
      chk("rst_r_ready", r_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst = 0;
      step();
      offer(16'hBEEF, 1, 16'hCAFE, 1);
      clear_obs();
      enable = 1;
      run(FRAME / 2 + 3 * PER);
      enable = 0;
      run_until_idle(FRAME + 16);
      chk("restart_left", rx_q[0], 16'hBEEF);
      chk("restart_right", rx_q[1], 16'hCAFE);
      run(4);

      // random stalls over 50 frames
      clear_obs();
      uf_snap = obs_uf_cnt;
      muf_snap = m_uf_cnt;
      enable = 1;
      for (int unsigned i = 0; i < 50 * FRAME; i++) begin
         l_valid = ($urandom_range(0, 63) == 0);
         r_valid = ($urandom_range(0, 63) == 0);
         l_data  = W'($urandom_range(1, 65535));
         r_data  = W'($urandom_range(1, 65535));
         step();
      end
      l_valid = 0; r_valid = 0;
      enable = 0;
      run_until_idle(FRAME + 16);
      cmp_streams("random_stream");
      chk("random_uf_count", obs_uf_cnt - uf_snap, m_uf_cnt - muf_snap);
      zeros = 0;
      foreach (rx_q[i]) if (rx_q[i] == '0) zeros++;
      chk("random_zero_slots", zeros, obs_uf_cnt - uf_snap);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
